// File: rtl/ledboard_frame_if.sv
// LED-board frame controller bus: FIFO read side plus board pins.
// master = frame controller, slave = FIFO/board environment.
interface ledboard_frame_if;
  logic       start;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       led_sclk;
  logic       led_sdata;
  logic       led_latch;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  modport master (
    input  start,
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en,
    output led_sclk,
    output led_sdata,
    output led_latch,
    output busy,
    output frame_done,
    output underrun
  );

  modport slave (
    output start,
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en,
    input  led_sclk,
    input  led_sdata,
    input  led_latch,
    input  busy,
    input  frame_done,
    input  underrun
  );
endinterface

// File: rtl/ledboard_frame_ctrl.sv
// Pops a frame from the LED-board FWFT FIFO, shifts it out MSB-first,
// then pulses the board latch and holds an inter-frame gap.
module ledboard_frame_ctrl #(
  parameter int FRAME_BYTES  = 66,
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 8,
  parameter int GAP_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst,
  ledboard_frame_if.master  bus
);

  localparam int BW = $clog2(FRAME_BYTES + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int WMAX =
    (LATCH_CYCLES > GAP_CYCLES) ? LATCH_CYCLES : GAP_CYCLES;
  localparam int WW = $clog2(WMAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [BW-1:0] LAST_BYTE  = BW'(FRAME_BYTES - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [WW-1:0] LATCH_LAST = WW'(LATCH_CYCLES - 1);
  localparam logic [WW-1:0] GAP_LAST   = WW'(GAP_CYCLES - 1);

  logic [2:0]    state;
  logic [BW-1:0] byte_cnt;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic [WW-1:0] wait_cnt;
  logic [7:0]    shift_reg;
  logic          sclk_q;
  logic          latch_q;
  logic          busy_q;
  logic          done_q;
  logic          underrun_q;

  assign bus.fifo_rd_en = (state == S_LOAD) && !bus.fifo_empty;
  // Data pin is the shift register MSB; it is zero outside a byte.
  assign bus.led_sdata  = shift_reg[7];
  assign bus.led_sclk   = sclk_q;
  assign bus.led_latch  = latch_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.underrun   = underrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      wait_cnt   <= '0;
      shift_reg  <= '0;
      sclk_q     <= 1'b0;
      latch_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            state      <= S_LOAD;
            busy_q     <= 1'b1;
            underrun_q <= 1'b0;
            byte_cnt   <= '0;
          end
        end
        S_LOAD: begin
          if (!bus.fifo_empty) begin
            shift_reg <= bus.fifo_data;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            state     <= S_SHIFT;
          end else begin
            underrun_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DW'(1);
          end else begin
            div_cnt <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // Falling sclk edge: advance data while clock goes low.
              sclk_q    <= 1'b0;
              shift_reg <= {shift_reg[6:0], 1'b0};
              if (bit_cnt != 3'd7) begin
                bit_cnt <= bit_cnt + 3'd1;
              end else if (byte_cnt == LAST_BYTE) begin
                state    <= S_LATCH;
                latch_q  <= 1'b1;
                wait_cnt <= '0;
              end else begin
                byte_cnt <= byte_cnt + BW'(1);
                state    <= S_LOAD;
              end
            end
          end
        end
        S_LATCH: begin
          if (wait_cnt != LATCH_LAST) begin
            wait_cnt <= wait_cnt + WW'(1);
          end else begin
            latch_q  <= 1'b0;
            wait_cnt <= '0;
            state    <= S_GAP;
            done_q   <= (GAP_CYCLES == 1);
          end
        end
        S_GAP: begin
          if (wait_cnt != GAP_LAST) begin
            wait_cnt <= wait_cnt + WW'(1);
            done_q   <= (wait_cnt + WW'(1) == GAP_LAST);
          end else begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ledboard_frame_ctrl.sv
// Scoreboard bench for ledboard_frame_ctrl: FIFO model feeds bytes,
// a monitor rebuilds serial bytes and checks pin timing.
module tb_ledboard_frame_ctrl;

  localparam int FB  = 66;
  localparam int DIV = 4;
  localparam int LW  = 8;
  localparam int GAP = 16;
  localparam int FRAME_CYC = 1 + FB * (1 + 16 * DIV) + LW + GAP;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ledboard_frame_if bif();

  ledboard_frame_ctrl #(
    .FRAME_BYTES (FB),
    .CLK_DIV     (DIV),
    .LATCH_CYCLES(LW),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int done_cnt = 0;
  int latch_cnt = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic drive_fifo();
    bif.fifo_empty = (fifo_q.size() == 0);
    bif.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    drive_fifo();
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_pulse();
    @(negedge clk);
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bif.frame_done && n < limit);
    chk("frame_done_seen", int'(bif.frame_done), 1);
  endtask

  task automatic chk_idle_pins(input string tag);
    chk({tag, "_sclk"},     int'(bif.led_sclk), 0);
    chk({tag, "_sdata"},    int'(bif.led_sdata), 0);
    chk({tag, "_latch"},    int'(bif.led_latch), 0);
    chk({tag, "_busy"},     int'(bif.busy), 0);
    chk({tag, "_done"},     int'(bif.frame_done), 0);
    chk({tag, "_underrun"}, int'(bif.underrun), 0);
    chk({tag, "_rd_en"},    int'(bif.fifo_rd_en), 0);
  endtask

  // FIFO model: pop on the edge where rd_en was seen with data present
  initial begin
    logic p;
    bif.start = 1'b0;
    drive_fifo();
    forever begin
      @(posedge clk);
      p = bif.fifo_rd_en && !bif.fifo_empty;
      #1;
      if (p) begin
        void'(fifo_q.pop_front());
        pops++;
        drive_fifo();
      end
    end
  end

  // Monitor: rebuild bytes on sclk rise, check phase widths and latch/gap
  logic       ps = 1'b0;
  logic       pl = 1'b0;
  logic       pd = 1'b0;
  logic [7:0] sh = 8'h00;
  int nb = 0, hi = 0, lo = 0, lw = 0, gcnt = 0;
  bit in_gap = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        nb = 0; hi = 0; lo = 0; lw = 0;
        in_gap = 1'b0;
      end else begin
        if (bif.led_sclk) hi = ps ? hi + 1 : 1;
        else              lo = ps ? 1 : lo + 1;
        if (bif.led_sdata !== pd)
          chk("sdata_change_sclk_low", int'(bif.led_sclk), 0);
        if (!ps && bif.led_sclk) begin
          if (nb != 0) chk("sclk_low_width", lo, DIV);
          sh = {sh[6:0], bif.led_sdata};
          nb++;
          if (nb == 8) begin
            nb = 0;
            if (exp_q.size() == 0) chk("byte_unexpected", int'(sh), -1);
            else chk("serial_byte", int'(sh), int'(exp_q.pop_front()));
          end
        end
        if (ps && !bif.led_sclk) chk("sclk_high_width", hi, DIV);
        if (bif.led_latch) lw++;
        if (!pl && bif.led_latch) latch_cnt++;
        if (pl && !bif.led_latch) begin
          chk("latch_width", lw, LW);
          lw = 0;
          in_gap = 1'b1;
          gcnt = 0;
        end
        if (in_gap) gcnt++;
        if (bif.frame_done) begin
          done_cnt++;
          chk("gap_to_done", in_gap ? gcnt : -1, GAP);
          in_gap = 1'b0;
        end
      end
      ps = bif.led_sclk;
      pl = bif.led_latch;
      pd = bif.led_sdata;
    end
  end

  initial begin
    int n, n2, p0, d0, l0, k;

    // reset held 5 cycles then released
    cyc(5);
    rst = 1'b0;
    cyc(1);
    chk_idle_pins("reset");

    // full frame 0x00..0x41 and its exact length
    p0 = pops;
    for (int i = 0; i < FB; i++) push(8'(i));
    start_pulse();
    chk("t1_busy", int'(bif.busy), 1);
    wait_done(6000, n);
    chk("t1_frame_cycles", n + 2, FRAME_CYC);
    chk("t1_pops", pops - p0, FB);
    chk("t1_underrun", int'(bif.underrun), 0);
    cyc(1);
    chk("t1_busy_after", int'(bif.busy), 0);

    // 0xA5 at the head: bit pattern and phase widths via monitor
    p0 = pops;
    push(8'hA5);
    for (int i = 1; i < FB; i++) push(8'(i * 3));
    start_pulse();
    wait_done(6000, n);
    chk("t2_frame_cycles", n + 2, FRAME_CYC);
    chk("t2_pops", pops - p0, FB);

    // underrun: stall after 10 bytes, resume when 56 more arrive
    p0 = pops;
    for (int i = 0; i < 10; i++) push(8'(8'h80 + i));
    start_pulse();
    k = 0;
    while (pops != p0 + 10 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    cyc(200);
    chk("t3_underrun", int'(bif.underrun), 1);
    chk("t3_sclk_low", int'(bif.led_sclk), 0);
    chk("t3_no_pop", int'(bif.fifo_rd_en), 0);
    chk("t3_busy", int'(bif.busy), 1);
    chk("t3_stalled_pops", pops - p0, 10);
    for (int i = 10; i < FB; i++) push(8'(8'h80 + i));
    wait_done(6000, n);
    chk("t3_underrun_sticky", int'(bif.underrun), 1);
    chk("t3_pops", pops - p0, FB);
    cyc(2);

    // reset during byte 20 aborts the frame
    p0 = pops;
    for (int i = 0; i < FB; i++) push(8'(i) ^ 8'h5A);
    start_pulse();
    cyc(2);
    chk("t4_underrun_cleared", int'(bif.underrun), 0);
    k = 0;
    while (pops != p0 + 20 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    cyc(30);
    chk("t4_mid_shift_busy", int'(bif.busy), 1);
    l0 = latch_cnt;
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_pins("t4_abort");
    fifo_q.delete();
    exp_q.delete();
    drive_fifo();
    cyc(100);
    chk("t4_no_latch", latch_cnt - l0, 0);
    chk("t4_no_done", done_cnt - d0, 0);
    p0 = pops;
    for (int i = 0; i < FB; i++) push(8'(i * 5));
    start_pulse();
    wait_done(6000, n);
    chk("t4_new_frame_cycles", n + 2, FRAME_CYC);
    chk("t4_new_frame_pops", pops - p0, FB);
    cyc(2);

    // start held: two frames back-to-back
    p0 = pops;
    l0 = latch_cnt;
    for (int i = 0; i < 2 * FB; i++) push(8'(i));
    @(negedge clk);
    bif.start = 1'b1;
    wait_done(6000, n);
    chk("t5_first_cycles", n + 1, FRAME_CYC);
    wait_done(6000, n2);
    bif.start = 1'b0;
    chk("t5_second_spacing", n2, FRAME_CYC);
    chk("t5_pops", pops - p0, 2 * FB);
    chk("t5_latches", latch_cnt - l0, 2);
    cyc(3);

    // start pulses in SHIFT, LATCH and GAP are ignored
    p0 = pops;
    d0 = done_cnt;
    for (int i = 0; i < FB; i++) push(8'(i + 7));
    start_pulse();
    k = 0;
    while (pops == p0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    start_pulse();
    k = 0;
    while (!bif.led_latch && k < 6000) begin
      @(negedge clk);
      k++;
    end
    chk("t6_latch_seen", int'(bif.led_latch), 1);
    start_pulse();
    k = 0;
    while (bif.led_latch && k < 100) begin
      @(negedge clk);
      k++;
    end
    start_pulse();
    wait_done(6000, n);
    cyc(100);
    chk("t6_one_done", done_cnt - d0, 1);
    chk("t6_pops", pops - p0, FB);
    chk("t6_idle", int'(bif.busy), 0);
    chk("t6_exp_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
